parity_frame_ctrl: RTL and testbench

PARITY_FRAME_CTRL -- requirements
Module: parity_frame_ctrl

---
 rtl/parity_frame_ctrl.sv | 146 ++++++++++++++
 tb/tb_parity_frame_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_ctrl.sv
// ---------------------------------------------------------------------------
// parity_frame_ctrl
//
// Frame parity controller. Each accepted byte is driven onto data_in, which
// feeds an external combinational parity generator. The controller waits
// SETTLE cycles and then samples the generator's par_bit. Across FRAME_LEN
// bytes it accumulates the frame parity and a count of odd-parity bytes. The
// result is then held on a valid/ready output until it is taken.
//
// Parameters
//   FRAME_LEN   bytes per frame, 1..15
//   SETTLE      cycles a byte is held on data_in before par_bit is sampled, 1..7
//   ODD         0 = even frame parity, 1 = odd frame parity
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     upstream byte available
//   in_ready     controller can accept a byte (IDLE only)
//   in_data      upstream byte
//   abort        discard the current frame (wins over everything else)
//   data_in      byte presented to the shared parity generator
//   par_bit      XOR-reduction of data_in from the generator
//   out_valid    frame result available
//   out_ready    downstream takes the result
//   out_parity   frame parity (acc ^ ODD), only meaningful with out_valid
//   out_odd_cnt  number of bytes in the frame whose par_bit was 1
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a byte; in_ready high
// DRIVE | byte on data_in; settle counter running, sample when it is 0
// DONE  | frame complete; result held until out_ready
// ---------------------------------------------------------------------------
module parity_frame_ctrl #(
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned SETTLE    = 1,
    parameter bit          ODD       = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       abort,
    output logic [7:0] data_in,
    input  logic       par_bit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_parity,
    output logic [3:0] out_odd_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE - 1);
    localparam logic [3:0] FRAME_LAST  = 4'(FRAME_LEN);

    state_t     state, state_nxt;
    logic       acc, acc_nxt;
    logic [3:0] byte_cnt, byte_cnt_nxt;
    logic [3:0] odd_cnt_nxt;
    logic [2:0] settle_cnt, settle_nxt;
    logic [7:0] data_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= 1'b0;
            byte_cnt    <= 4'd0;
            out_odd_cnt <= 4'd0;
            settle_cnt  <= 3'd0;
            data_in     <= 8'h00;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            byte_cnt    <= byte_cnt_nxt;
            out_odd_cnt <= odd_cnt_nxt;
            settle_cnt  <= settle_nxt;
            data_in     <= data_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        byte_cnt_nxt = byte_cnt;
        odd_cnt_nxt  = out_odd_cnt;
        settle_nxt   = settle_cnt;
        data_nxt     = data_in;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_parity   = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_nxt   = in_data;
                    settle_nxt = SETTLE_LOAD;
                    state_nxt  = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_cnt != 3'd0) begin
                    settle_nxt = settle_cnt - 3'd1;
                end else begin
                    acc_nxt      = acc ^ par_bit;
                    odd_cnt_nxt  = out_odd_cnt + {3'b000, par_bit};
                    byte_cnt_nxt = byte_cnt + 4'd1;
                    state_nxt    = ((byte_cnt + 4'd1) == FRAME_LAST) ? DONE : IDLE;
                end
            end
            DONE: begin
                out_valid  = 1'b1;
                // Gated by DONE so out_parity reads 0 in reset/idle even when ODD=1.
                out_parity = acc ^ ODD;
                if (out_ready) begin
                    acc_nxt      = 1'b0;
                    byte_cnt_nxt = 4'd0;
                    odd_cnt_nxt  = 4'd0;
                    state_nxt    = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort overrides acceptance, sampling and the result handshake, but
        // leaves the last byte on data_in.
        if (abort) begin
            state_nxt    = IDLE;
            acc_nxt      = 1'b0;
            byte_cnt_nxt = 4'd0;
            odd_cnt_nxt  = 4'd0;
            settle_nxt   = 3'd0;
            data_nxt     = data_in;
        end
    end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
module tb_parity_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, in_valid, abort, out_ready;
    logic [7:0] in_data;

    logic       a_in_ready, a_out_valid, a_out_parity, a_par_bit;
    logic [7:0] a_data_in;
    logic [3:0] a_odd_cnt;

    logic       b_in_ready, b_out_valid, b_out_parity, b_par_bit;
    logic [7:0] b_data_in;
    logic [3:0] b_odd_cnt;

    logic       c_in_valid, c_abort, c_out_ready, c_glitch;
    logic [7:0] c_in_data;
    logic       c_in_ready, c_out_valid, c_out_parity, c_par_bit;
    logic [7:0] c_data_in;
    logic [3:0] c_odd_cnt;

    // External parity generator; c_glitch corrupts it outside the sample cycle.
    assign a_par_bit = ^a_data_in;
    assign b_par_bit = ^b_data_in;
    assign c_par_bit = (^c_data_in) ^ c_glitch;

    int total  = 0;
    int passed = 0;

    parity_frame_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .abort(abort), .data_in(a_data_in), .par_bit(a_par_bit),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_parity(a_out_parity),
        .out_odd_cnt(a_odd_cnt));

    parity_frame_ctrl #(.ODD(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .abort(abort), .data_in(b_data_in), .par_bit(b_par_bit),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_parity(b_out_parity),
        .out_odd_cnt(b_odd_cnt));

    parity_frame_ctrl #(.FRAME_LEN(1), .SETTLE(3)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .abort(c_abort), .data_in(c_data_in), .par_bit(c_par_bit),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_parity(c_out_parity),
        .out_odd_cnt(c_odd_cnt));

    // Reference model: count of bytes with an odd number of ones.
    function automatic int odd_bytes(input logic [7:0] q[$]);
        int n = 0;
        foreach (q[i]) n += $countones(q[i]) % 2;
        return n;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit last, input string tag);
        int n = 0;
        while (a_in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        total++; if (n >= 100) $display("FAIL %s_wait_ready: in_ready=%b after %0d cycles", tag, a_in_ready, n); else passed++;
        in_valid = 1'b1; in_data = b;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 8'($urandom);
        total++; if (a_data_in !== b) $display("FAIL %s_data_in: got %h want %h", tag, a_data_in, b); else passed++;
        total++; if (b_data_in !== b) $display("FAIL %s_b_data_in: got %h want %h", tag, b_data_in, b); else passed++;
        total++; if (a_in_ready !== 1'b0) $display("FAIL %s_drive_ready: got %b want 0", tag, a_in_ready); else passed++;
        @(posedge clk); #1;
        total++; if (a_in_ready !== !last) $display("FAIL %s_post_sample_ready: got %b want %b", tag, a_in_ready, !last); else passed++;
        total++; if (a_out_valid !== last) $display("FAIL %s_post_sample_valid: got %b want %b", tag, a_out_valid, last); else passed++;
    endtask

    task automatic send_frame(input logic [7:0] q[$], input bit rand_gap, input string tag);
        for (int i = 0; i < q.size(); i++) begin
            if (rand_gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_byte(q[i], i == q.size() - 1, tag);
        end
    endtask

    task automatic get_result(input bit ep_a, input bit ep_b, input int ecnt, input int hold,
                              input logic [7:0] last_b, input string tag);
        int n = 0;
        while (a_out_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        total++; if (n >= 100) $display("FAIL %s_wait_valid: out_valid=%b", tag, a_out_valid); else passed++;
        total++; if (b_out_valid !== 1'b1) $display("FAIL %s_b_valid: got %b want 1", tag, b_out_valid); else passed++;
        total++; if (a_out_parity !== ep_a) $display("FAIL %s_parity: got %b want %b", tag, a_out_parity, ep_a); else passed++;
        total++; if (b_out_parity !== ep_b) $display("FAIL %s_odd_parity: got %b want %b", tag, b_out_parity, ep_b); else passed++;
        total++; if (a_odd_cnt !== 4'(ecnt)) $display("FAIL %s_odd_cnt: got %0d want %0d", tag, a_odd_cnt, ecnt); else passed++;
        total++; if (b_odd_cnt !== 4'(ecnt)) $display("FAIL %s_b_odd_cnt: got %0d want %0d", tag, b_odd_cnt, ecnt); else passed++;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            @(posedge clk); #1;
            total++; if (a_out_valid !== 1'b1 || a_out_parity !== ep_a || a_odd_cnt !== 4'(ecnt))
                $display("FAIL %s_hold%0d: valid=%b par=%b cnt=%0d want 1 %b %0d", tag, k, a_out_valid, a_out_parity, a_odd_cnt, ep_a, ecnt);
            else passed++;
            total++; if (a_in_ready !== 1'b0) $display("FAIL %s_hold_ready%0d: got %b want 0", tag, k, a_in_ready); else passed++;
        end
        in_valid = 1'b1; in_data = 8'($urandom);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        total++; if (a_out_valid !== 1'b0) $display("FAIL %s_after_ack_valid: got %b want 0", tag, a_out_valid); else passed++;
        total++; if (a_in_ready !== 1'b1) $display("FAIL %s_after_ack_ready: got %b want 1", tag, a_in_ready); else passed++;
        total++; if (a_odd_cnt !== 4'd0 || b_odd_cnt !== 4'd0) $display("FAIL %s_after_ack_cnt: got %0d/%0d want 0", tag, a_odd_cnt, b_odd_cnt); else passed++;
        total++; if (a_data_in !== last_b) $display("FAIL %s_after_ack_data: got %h want %h", tag, a_data_in, last_b); else passed++;
    endtask

    task automatic run_frame(input logic [7:0] q[$], input bit rand_gap, input int hold, input string tag);
        int n = odd_bytes(q);
        send_frame(q, rand_gap, tag);
        get_result(bit'(n % 2), bit'(n % 2) ^ 1'b1, n, hold, q[q.size() - 1], tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        c_in_valid = 1'b0; c_abort = 1'b0; c_out_ready = 1'b0; c_glitch = 1'b0; c_in_data = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        total++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b%b%b want 111", a_in_ready, b_in_ready, c_in_ready); else passed++;
        total++; if (a_data_in !== 8'h00) $display("FAIL reset_data_in: got %h want 00", a_data_in); else passed++;
        total++; if (a_out_valid !== 1'b0 || c_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b%b want 00", a_out_valid, c_out_valid); else passed++;
        total++; if (a_out_parity !== 1'b0 || b_out_parity !== 1'b0) $display("FAIL reset_out_parity: got %b%b want 00", a_out_parity, b_out_parity); else passed++;
        total++; if (a_odd_cnt !== 4'd0) $display("FAIL reset_odd_cnt: got %0d want 0", a_odd_cnt); else passed++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [7:0] q[$];
        q = '{8'hBD, 8'h04, 8'h64, 8'hFF};
        send_frame(q, 1'b0, "vec");
        get_result(1'b0, 1'b1, 2, 0, 8'hFF, "vec");
    endtask

    task automatic test_backpressure();
        logic [7:0] q[$];
        q = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        run_frame(q, 1'b1, 10, "bp");
    endtask

    task automatic test_abort();
        logic [7:0] q[$];
        send_byte(8'h01, 1'b0, "ab_a");
        send_byte(8'h07, 1'b0, "ab_b");
        total++; if (a_odd_cnt !== 4'd2) $display("FAIL abort_pre_cnt: got %0d want 2", a_odd_cnt); else passed++;
        abort = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        total++; if (a_in_ready !== 1'b1) $display("FAIL abort_idle_ready: got %b want 1", a_in_ready); else passed++;
        total++; if (a_odd_cnt !== 4'd0) $display("FAIL abort_idle_cnt: got %0d want 0", a_odd_cnt); else passed++;
        total++; if (a_data_in !== 8'h07) $display("FAIL abort_idle_data: got %h want 07", a_data_in); else passed++;
        q = '{8'h01, 8'h01, 8'h01, 8'h01};
        send_frame(q, 1'b0, "ab_f");
        get_result(1'b0, 1'b1, 4, 0, 8'h01, "ab_f");

        // abort while DONE
        q = '{8'h03, 8'h01, 8'h80, 8'h11};
        send_frame(q, 1'b0, "ab_done");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) $display("FAIL abort_done: valid=%b ready=%b want 0 1", a_out_valid, a_in_ready); else passed++;
        total++; if (a_odd_cnt !== 4'd0) $display("FAIL abort_done_cnt: got %0d want 0", a_odd_cnt); else passed++;

        // abort on the sample cycle: byte is not counted
        in_valid = 1'b1; in_data = 8'h01;
        @(posedge clk); #1;
        in_valid = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++; if (a_odd_cnt !== 4'd0 || a_in_ready !== 1'b1) $display("FAIL abort_sample: cnt=%0d ready=%b want 0 1", a_odd_cnt, a_in_ready); else passed++;
        total++; if (a_data_in !== 8'h01) $display("FAIL abort_sample_data: got %h want 01", a_data_in); else passed++;
        q = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        run_frame(q, 1'b0, 0, "ab_after");
    endtask

    task automatic test_reset_mid();
        logic [7:0] q[$];
        send_byte(8'h01, 1'b0, "rm_a");
        total++; if (a_odd_cnt !== 4'd1) $display("FAIL rstmid_pre_cnt: got %0d want 1", a_odd_cnt); else passed++;
        in_valid = 1'b1; in_data = 8'h37;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (a_in_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", a_in_ready); else passed++;
        total++; if (a_data_in !== 8'h00) $display("FAIL rstmid_data: got %h want 00", a_data_in); else passed++;
        total++; if (a_odd_cnt !== 4'd0 || a_out_valid !== 1'b0 || a_out_parity !== 1'b0) $display("FAIL rstmid_out: cnt=%0d valid=%b par=%b want 0 0 0", a_odd_cnt, a_out_valid, a_out_parity); else passed++;
        #2 rst_n = 1'b1;
        q = '{8'hC3, 8'($urandom), 8'($urandom), 8'($urandom)};
        run_frame(q, 1'b0, 1, "rm_f");
    endtask

    task automatic test_settle();
        logic [7:0] bytes [2];
        bytes[0] = 8'h01; bytes[1] = 8'h03;
        for (int t = 0; t < 2; t++) begin
            c_glitch = 1'b1;
            c_in_valid = 1'b1; c_in_data = bytes[t];
            @(posedge clk); #1;
            c_in_valid = 1'b0; c_in_data = 8'($urandom);
            for (int k = 0; k < 3; k++) begin
                if (k == 2) c_glitch = 1'b0;
                total++; if (c_data_in !== bytes[t] || c_out_valid !== 1'b0 || c_in_ready !== 1'b0)
                    $display("FAIL settle%0d_drive%0d: data=%h valid=%b ready=%b want %h 0 0", t, k, c_data_in, c_out_valid, c_in_ready, bytes[t]);
                else passed++;
                @(posedge clk); #1;
            end
            c_glitch = 1'b1;
            total++; if (c_out_valid !== 1'b1) $display("FAIL settle%0d_valid: got %b want 1", t, c_out_valid); else passed++;
            total++; if (c_out_parity !== bit'($countones(bytes[t]) % 2)) $display("FAIL settle%0d_parity: got %b want %b", t, c_out_parity, bit'($countones(bytes[t]) % 2)); else passed++;
            total++; if (c_odd_cnt !== 4'($countones(bytes[t]) % 2)) $display("FAIL settle%0d_cnt: got %0d want %0d", t, c_odd_cnt, $countones(bytes[t]) % 2); else passed++;
            c_out_ready = 1'b1;
            @(posedge clk); #1;
            c_out_ready = 1'b0; c_glitch = 1'b0;
            total++; if (c_in_ready !== 1'b1 || c_odd_cnt !== 4'd0) $display("FAIL settle%0d_ack: ready=%b cnt=%0d want 1 0", t, c_in_ready, c_odd_cnt); else passed++;
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        for (int f = 0; f < 20; f++) begin
            q = {};
            for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
            run_frame(q, 1'b1, int'($urandom_range(0, 3)), "rnd");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_settle();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
